// File: rtl/lock_pkg.sv
// lock_pkg: shared types, constants and helpers for the door-lock configuration path.
//   pinPac_t   - one PIN: enable status plus four BCD digits (digit1 leftmost)
//   setupPac_t - full lock configuration edited by the setup menu
//   bcdPac_t   - six display digits, BCD0 rightmost
//   state_t    - setup menu states; the encoding equals the step number shown to the user
package lock_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        pinPac_t    pin1;
        pinPac_t    pin2;
        pinPac_t    pin3;
        pinPac_t    pin4;
    } setupPac_t;

    typedef struct packed {
        logic [3:0] BCD0;
        logic [3:0] BCD1;
        logic [3:0] BCD2;
        logic [3:0] BCD3;
        logic [3:0] BCD4;
        logic [3:0] BCD5;
    } bcdPac_t;

    localparam logic [3:0] KEY_CONFIRM = 4'hF;
    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [6:0] TIME_MIN    = 7'd5;
    localparam logic [6:0] TIME_MAX    = 7'd60;

    // Encoding doubles as the step number n displayed on BCD5:BCD4.
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        ATIVAR_BIP  = 4'd1,
        BIP_TIME    = 4'd2,
        TRANCA_TIME = 4'd3,
        PIN1        = 4'd4,
        ATIVAR_PIN2 = 4'd5,
        PIN2        = 4'd6,
        ATIVAR_PIN3 = 4'd7,
        PIN3        = 4'd8,
        ATIVAR_PIN4 = 4'd9,
        PIN4        = 4'd10,
        FIM         = 4'd11
    } state_t;

    // Two BCD digits to a time value, clamped to the legal range.
    function automatic logic [6:0] time_from_digits(input logic [3:0] tens,
                                                    input logic [3:0] units);
        logic [7:0] value;
        value = ({4'd0, tens} * 8'd10) + {4'd0, units};
        if (value < {1'b0, TIME_MIN}) begin
            return TIME_MIN;
        end else if (value > {1'b0, TIME_MAX}) begin
            return TIME_MAX;
        end else begin
            return value[6:0];
        end
    endfunction

    // A confirmed PIN is always enabled.
    function automatic pinPac_t pin_from_digits(input logic [3:0] d1, input logic [3:0] d2,
                                                input logic [3:0] d3, input logic [3:0] d4);
        pinPac_t p;
        p.status = 1'b1;
        p.digit1 = d1;
        p.digit2 = d2;
        p.digit3 = d3;
        p.digit4 = d4;
        return p;
    endfunction

endpackage

// File: rtl/setup_ctrl_bin2bcd.sv
// bin2bcd_2digit: combinational 7-bit binary (0..99) to two BCD digits.
//   bin_in - binary value; anything above 99 saturates to 99
//   tens   - tens digit
//   units  - units digit
module bin2bcd_2digit (
    input  logic [6:0] bin_in,
    output logic [3:0] tens,
    output logic [3:0] units
);

    // Divide by ten; saturate so an out-of-range stored time still shows valid digits.
    always_comb begin
        if (bin_in > 7'd99) begin
            tens  = 4'd9;
            units = 4'd9;
        end else begin
            tens  = 4'(bin_in / 7'd10);
            units = 4'(bin_in % 7'd10);
        end
    end

endmodule

// File: rtl/setup_ctrl.sv
// setup_ctrl: keypad-driven configuration menu for the door lock.
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   key_valid       - one-cycle strobe qualifying key_code
//   key_code        - 0..9 digits, 0xF confirm, 0xA..0xE ignored
//   setup_on        - request to enter the menu, honoured only in IDLE
//   data_setup_old  - current configuration, copied in on entry
//   data_setup_new  - registered working copy of the configuration
//   bcd_out         - six display digits, decoded from registered state
//   bcd_enable      - display enable, high outside IDLE
//   setup_end       - one-cycle pulse while in FIM
module setup_ctrl
    import lock_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      key_valid,
    input  logic [3:0] key_code,
    input  logic      setup_on,
    input  setupPac_t data_setup_old,
    output setupPac_t data_setup_new,
    output bcdPac_t   bcd_out,
    output logic      bcd_enable,
    output logic      setup_end
);

    state_t    state_q, state_d;
    setupPac_t data_q, data_d;
    // Entry buffer: toggle uses buf4, time uses buf3:buf4 (tens:units), PIN uses buf1..buf4.
    logic [3:0] buf1_q, buf2_q, buf3_q, buf4_q;
    logic [3:0] buf1_d, buf2_d, buf3_d, buf4_d;
    logic       is_digit, is_confirm;
    logic [6:0] time_bin;
    logic [3:0] time_tens, time_units;
    logic [3:0] step;

    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_confirm = key_valid && (key_code == KEY_CONFIRM);

    // Preload source for time states: the field of the state being entered.
    assign time_bin = (state_d == TRANCA_TIME) ? data_d.tranca_aut_time : data_d.bip_time;

    bin2bcd_2digit u_bin2bcd (
        .bin_in (time_bin),
        .tens   (time_tens),
        .units  (time_units)
    );

    // Next state and working-copy update on confirm.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (setup_on) begin
                    data_d  = data_setup_old;
                    state_d = ATIVAR_BIP;
                end else begin
                    state_d = IDLE;
                end
            end
            ATIVAR_BIP: begin
                if (is_confirm) begin
                    data_d.bip_status = buf4_q[0];
                    state_d = BIP_TIME;
                end else begin
                    state_d = ATIVAR_BIP;
                end
            end
            BIP_TIME: begin
                if (is_confirm) begin
                    data_d.bip_time = time_from_digits(buf3_q, buf4_q);
                    state_d = TRANCA_TIME;
                end else begin
                    state_d = BIP_TIME;
                end
            end
            TRANCA_TIME: begin
                if (is_confirm) begin
                    data_d.tranca_aut_time = time_from_digits(buf3_q, buf4_q);
                    state_d = PIN1;
                end else begin
                    state_d = TRANCA_TIME;
                end
            end
            PIN1: begin
                if (is_confirm) begin
                    data_d.pin1 = pin_from_digits(buf1_q, buf2_q, buf3_q, buf4_q);
                    state_d = ATIVAR_PIN2;
                end else begin
                    state_d = PIN1;
                end
            end
            ATIVAR_PIN2: begin
                if (is_confirm) begin
                    data_d.pin2.status = buf4_q[0];
                    state_d = buf4_q[0] ? PIN2 : ATIVAR_PIN3;
                end else begin
                    state_d = ATIVAR_PIN2;
                end
            end
            PIN2: begin
                if (is_confirm) begin
                    data_d.pin2 = pin_from_digits(buf1_q, buf2_q, buf3_q, buf4_q);
                    state_d = ATIVAR_PIN3;
                end else begin
                    state_d = PIN2;
                end
            end
            ATIVAR_PIN3: begin
                if (is_confirm) begin
                    data_d.pin3.status = buf4_q[0];
                    state_d = buf4_q[0] ? PIN3 : ATIVAR_PIN4;
                end else begin
                    state_d = ATIVAR_PIN3;
                end
            end
            PIN3: begin
                if (is_confirm) begin
                    data_d.pin3 = pin_from_digits(buf1_q, buf2_q, buf3_q, buf4_q);
                    state_d = ATIVAR_PIN4;
                end else begin
                    state_d = PIN3;
                end
            end
            ATIVAR_PIN4: begin
                if (is_confirm) begin
                    data_d.pin4.status = buf4_q[0];
                    state_d = buf4_q[0] ? PIN4 : FIM;
                end else begin
                    state_d = ATIVAR_PIN4;
                end
            end
            PIN4: begin
                if (is_confirm) begin
                    data_d.pin4 = pin_from_digits(buf1_q, buf2_q, buf3_q, buf4_q);
                    state_d = FIM;
                end else begin
                    state_d = PIN4;
                end
            end
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entry buffer: preload from the updated working copy on a state change, else shift digits in.
    always_comb begin
        buf1_d = buf1_q;
        buf2_d = buf2_q;
        buf3_d = buf3_q;
        buf4_d = buf4_q;
        if (state_d != state_q) begin
            case (state_d)
                ATIVAR_BIP:  buf4_d = {3'b000, data_d.bip_status};
                ATIVAR_PIN2: buf4_d = {3'b000, data_d.pin2.status};
                ATIVAR_PIN3: buf4_d = {3'b000, data_d.pin3.status};
                ATIVAR_PIN4: buf4_d = {3'b000, data_d.pin4.status};
                BIP_TIME, TRANCA_TIME: begin
                    buf3_d = time_tens;
                    buf4_d = time_units;
                end
                PIN1: {buf1_d, buf2_d, buf3_d, buf4_d} = {data_d.pin1.digit1, data_d.pin1.digit2,
                                                          data_d.pin1.digit3, data_d.pin1.digit4};
                PIN2: {buf1_d, buf2_d, buf3_d, buf4_d} = {data_d.pin2.digit1, data_d.pin2.digit2,
                                                          data_d.pin2.digit3, data_d.pin2.digit4};
                PIN3: {buf1_d, buf2_d, buf3_d, buf4_d} = {data_d.pin3.digit1, data_d.pin3.digit2,
                                                          data_d.pin3.digit3, data_d.pin3.digit4};
                PIN4: {buf1_d, buf2_d, buf3_d, buf4_d} = {data_d.pin4.digit1, data_d.pin4.digit2,
                                                          data_d.pin4.digit3, data_d.pin4.digit4};
                default: buf4_d = buf4_q;
            endcase
        end else if (is_digit) begin
            case (state_q)
                ATIVAR_BIP, ATIVAR_PIN2, ATIVAR_PIN3, ATIVAR_PIN4: begin
                    if (key_code <= 4'd1) begin
                        buf4_d = key_code;
                    end else begin
                        buf4_d = buf4_q;
                    end
                end
                BIP_TIME, TRANCA_TIME: begin
                    buf3_d = buf4_q;
                    buf4_d = key_code;
                end
                PIN1, PIN2, PIN3, PIN4: begin
                    buf1_d = buf2_q;
                    buf2_d = buf3_q;
                    buf3_d = buf4_q;
                    buf4_d = key_code;
                end
                default: buf4_d = buf4_q;
            endcase
        end else begin
            buf4_d = buf4_q;
        end
    end

    // Menu state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working copy and entry buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            buf1_q <= 4'd0;
            buf2_q <= 4'd0;
            buf3_q <= 4'd0;
            buf4_q <= 4'd0;
        end else begin
            data_q <= data_d;
            buf1_q <= buf1_d;
            buf2_q <= buf2_d;
            buf3_q <= buf3_d;
            buf4_q <= buf4_d;
        end
    end

    assign step = state_q;

    // Display decode from registered state and buffer.
    always_comb begin
        bcd_out = '0;
        if (step >= 4'd10) begin
            bcd_out.BCD5 = 4'd1;
            bcd_out.BCD4 = step - 4'd10;
        end else begin
            bcd_out.BCD5 = 4'd0;
            bcd_out.BCD4 = step;
        end
        case (state_q)
            ATIVAR_BIP, ATIVAR_PIN2, ATIVAR_PIN3, ATIVAR_PIN4: begin
                bcd_out.BCD3 = BCD_BLANK;
                bcd_out.BCD2 = BCD_BLANK;
                bcd_out.BCD1 = BCD_BLANK;
                bcd_out.BCD0 = buf4_q;
            end
            BIP_TIME, TRANCA_TIME: begin
                bcd_out.BCD3 = BCD_BLANK;
                bcd_out.BCD2 = BCD_BLANK;
                bcd_out.BCD1 = buf3_q;
                bcd_out.BCD0 = buf4_q;
            end
            PIN1, PIN2, PIN3, PIN4: begin
                bcd_out.BCD3 = buf1_q;
                bcd_out.BCD2 = buf2_q;
                bcd_out.BCD1 = buf3_q;
                bcd_out.BCD0 = buf4_q;
            end
            default: bcd_out = '0;
        endcase
    end

    assign data_setup_new = data_q;
    assign bcd_enable     = (state_q != IDLE);
    assign setup_end      = (state_q == FIM);

endmodule

// File: tb/tb_setup_ctrl.sv
`timescale 1ns/1ps
module tb_setup_ctrl;
    import lock_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      key_valid;
    logic [3:0] key_code;
    logic      setup_on;
    setupPac_t data_setup_old;
    setupPac_t data_setup_new;
    bcdPac_t   bcd_out;
    logic      bcd_enable;
    logic      setup_end;

    int checks   = 0;
    int failures = 0;
    int end_cnt  = 0;
    setupPac_t exp_cfg;

    setup_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .setup_on       (setup_on),
        .data_setup_old (data_setup_old),
        .data_setup_new (data_setup_new),
        .bcd_out        (bcd_out),
        .bcd_enable     (bcd_enable),
        .setup_end      (setup_end)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (setup_end) end_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected digits written as BCD5 BCD4 BCD3 BCD2 BCD1 BCD0.
    task automatic disp(input string tag, input logic [23:0] exp);
        chk(tag, {bcd_out.BCD5, bcd_out.BCD4, bcd_out.BCD3,
                  bcd_out.BCD2, bcd_out.BCD1, bcd_out.BCD0}, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter();
        setup_on = 1'b1;
        @(posedge clk);
        #1;
        setup_on = 1'b0;
    endtask

    task automatic keys4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; setup_on = 1'b0;
        data_setup_old = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_setup_new, 128'd0);
        disp("rst_bcd", 24'h000000);
        chk("rst_en", bcd_enable, 128'd0);
        chk("rst_end", setup_end, 128'd0);
        rst = 1'b0;
        cyc();

        // ---- full menu ----
        enter();
        chk("t1_entry_en", bcd_enable, 128'd1);
        disp("t1_ativar_bip", 24'h01FFF0);
        press(4'h1);
        disp("t1_bip_one", 24'h01FFF1);
        press(4'hF);
        disp("t1_bip_time_pre", 24'h02FF00);
        press(4'h2); press(4'h3);
        disp("t1_bip_time_23", 24'h02FF23);
        press(4'hF);
        press(4'h1); press(4'h5); press(4'hF);
        disp("t1_pin1_pre", 24'h040000);
        press(4'h7); press(4'h8);
        disp("t1_pin1_78", 24'h040078);
        keys4(4'h1, 4'h2, 4'h3, 4'h4);
        disp("t1_pin1_1234", 24'h041234);
        press(4'hF);
        disp("t1_ativar_pin2", 24'h05FFF0);
        press(4'h1); press(4'hF);
        disp("t1_pin2_pre", 24'h060000);
        keys4(4'h5, 4'h6, 4'h7, 4'h8); press(4'hF);
        press(4'h1); press(4'hF);
        keys4(4'h9, 4'h0, 4'h1, 4'h2); press(4'hF);
        press(4'h1); press(4'hF);
        keys4(4'h3, 4'h4, 4'h5, 4'h6); press(4'hF);
        chk("t1_fim_end", setup_end, 128'd1);
        chk("t1_fim_en", bcd_enable, 128'd1);
        disp("t1_fim_bcd", 24'h000000);
        cyc();
        chk("t1_idle_end", setup_end, 128'd0);
        chk("t1_idle_en", bcd_enable, 128'd0);
        chk("t1_end_cnt", end_cnt, 128'd1);
        exp_cfg = '0;
        exp_cfg.bip_status = 1'b1;
        exp_cfg.bip_time = 7'd23;
        exp_cfg.tranca_aut_time = 7'd15;
        exp_cfg.pin1 = {1'b1, 16'h1234};
        exp_cfg.pin2 = {1'b1, 16'h5678};
        exp_cfg.pin3 = {1'b1, 16'h9012};
        exp_cfg.pin4 = {1'b1, 16'h3456};
        chk("t1_data", data_setup_new, exp_cfg);

        // ---- keys in IDLE ignored, working copy held ----
        press(4'h1);
        chk("idle_key_en", bcd_enable, 128'd0);
        chk("idle_hold", data_setup_new, exp_cfg);

        // ---- keep old values with F only ----
        data_setup_old = '0;
        data_setup_old.bip_status = 1'b1;
        data_setup_old.bip_time = 7'd30;
        data_setup_old.tranca_aut_time = 7'd20;
        data_setup_old.pin1 = {1'b0, 16'h4321};
        data_setup_old.pin2 = {1'b1, 16'h5555};
        data_setup_old.pin3 = {1'b0, 16'h7777};
        data_setup_old.pin4 = {1'b0, 16'h2222};
        enter();
        chk("t2_entry_copy", data_setup_new, data_setup_old);
        disp("t2_ativar_bip", 24'h01FFF1);
        press(4'hA);
        disp("t2_key_a_ignored", 24'h01FFF1);
        press(4'h5);
        disp("t2_key_5_ignored", 24'h01FFF1);
        press(4'hF);
        disp("t2_bip_time_30", 24'h02FF30);
        enter();
        disp("t2_setup_on_ignored", 24'h02FF30);
        press(4'hF);
        disp("t2_tranca_20", 24'h03FF20);
        press(4'hF);
        disp("t2_pin1_4321", 24'h044321);
        press(4'hF);
        disp("t2_ativar_pin2", 24'h05FFF1);
        press(4'hF);
        disp("t2_pin2_5555", 24'h065555);
        press(4'hF);
        disp("t2_ativar_pin3", 24'h07FFF0);
        press(4'hF);
        disp("t2_ativar_pin4", 24'h09FFF0);
        press(4'hF);
        chk("t2_fim_end", setup_end, 128'd1);
        cyc();
        exp_cfg = data_setup_old;
        exp_cfg.pin1.status = 1'b1;
        chk("t2_data", data_setup_new, exp_cfg);
        chk("t2_end_cnt", end_cnt, 128'd2);

        // ---- clamping and disabled PIN2 ----
        data_setup_old = '0;
        enter();
        press(4'h1); press(4'hF);
        press(4'h9); press(4'h9); press(4'hF);
        disp("t3_tranca_pre", 24'h03FF00);
        chk("t3_clamp_hi", data_setup_new.bip_time, 128'd60);
        press(4'h0); press(4'h2); press(4'hF);
        chk("t3_clamp_lo", data_setup_new.tranca_aut_time, 128'd5);
        disp("t3_pin1", 24'h040000);
        press(4'hF);
        press(4'h0); press(4'hF);
        disp("t3_skip_to_07", 24'h07FFF0);
        chk("t3_pin2_status", data_setup_new.pin2.status, 128'd0);
        press(4'h1); press(4'hF);
        disp("t3_pin3_pre", 24'h080000);
        press(4'h9);
        disp("t3_pin3_9", 24'h080009);
        press(4'hF);
        disp("t3_ativar_pin4", 24'h09FFF0);
        press(4'h0); press(4'hF);
        chk("t3_fim_end", setup_end, 128'd1);
        cyc();
        chk("t3_pin3", data_setup_new.pin3, {1'b1, 16'h0009});
        chk("t3_pin4_status", data_setup_new.pin4.status, 128'd0);
        chk("t3_pin1_status", data_setup_new.pin1.status, 128'd1);
        chk("t3_end_cnt", end_cnt, 128'd3);

        // ---- reset in the middle of PIN2 ----
        enter();
        press(4'hF); press(4'hF); press(4'hF); press(4'hF);
        press(4'h1); press(4'hF);
        disp("t4_pin2", 24'h060000);
        press(4'h5);
        disp("t4_pin2_5", 24'h060005);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_data", data_setup_new, 128'd0);
        disp("t4_rst_bcd", 24'h000000);
        chk("t4_rst_en", bcd_enable, 128'd0);
        chk("t4_rst_end", setup_end, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        cyc();
        chk("t4_no_end", end_cnt, 128'd3);
        chk("t4_idle_en", bcd_enable, 128'd0);
        press(4'hF);
        chk("t4_idle_key", bcd_enable, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
